// File: rtl/mbox_pkg.sv
// Shared types and helpers for the message-box transmit path.
// Provides the sender state enum, header field positions and length width.
package mbox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } mbox_tx_state_e;

  // Length occupies the low header bits, ID the top bits.
  localparam int HDR_LEN_LSB = 0;

  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int hdr_id_lsb(input int dw, input int idw);
    return dw - idw;
  endfunction

endpackage

// File: rtl/mbox_msg_buf.sv
// Payload word store: DEPTH x DATA_WIDTH array, no reset.
// Ports: clk, we_i/waddr_i/wdata_i write, raddr_i/rdata_o comb read.
module mbox_msg_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mbox_msg_sender.sv
// Message-box sender: host loads payload, doorbell emits header + payload.
// Ports: host wr_en_i/wr_data_i/send_i/msg_id_i, status busy/done/drop, out_* stream.
module mbox_msg_sender
  import mbox_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  send_i,
  input  logic [ID_WIDTH-1:0]   msg_id_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  drop_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o
);

  localparam int LEN_W  = len_w(DEPTH);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ID_LSB = hdr_id_lsb(DATA_WIDTH, ID_WIDTH);

  mbox_tx_state_e state_q;

  logic [IDX_W-1:0]      wr_ptr_q;
  logic [IDX_W-1:0]      rd_ptr_q;
  logic [LEN_W-1:0]      count_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  busy_q;
  logic                  valid_q;
  logic                  done_q;
  logic                  drop_q;
  logic                  wr_ok;
  logic                  xfer;
  logic                  last_w;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] data_w;

  assign wr_ok = (state_q == IDLE) && wr_en_i
              && (count_q < LEN_W'(DEPTH));
  assign xfer  = valid_q && out_ready_i;

  // A write accepted alongside the doorbell joins the message.
  assign len_d = count_q + LEN_W'(wr_ok);

  mbox_msg_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_buf (
    .clk    (clk),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  // Stream word decodes only registered state, so it is
  // stable while valid waits for ready.
  always_comb begin
    hdr = '0;
    hdr[ID_LSB +: ID_WIDTH]     = id_q;
    hdr[HDR_LEN_LSB +: LEN_W]   = len_q;
    data_w = '0;
    last_w = 1'b0;
    unique case (state_q)
      HDR: begin
        data_w = hdr;
        last_w = (len_q == '0);
      end
      PAYLOAD: begin
        data_w = rd_data;
        last_w = (LEN_W'(rd_ptr_q) == len_q - LEN_W'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_en_i) begin
            if (wr_ok) begin
              wr_ptr_q <= wr_ptr_q + IDX_W'(1);
              count_q  <= count_q + LEN_W'(1);
            end else begin
              drop_q <= 1'b1;
            end
          end
          if (send_i) begin
            id_q    <= msg_id_i;
            len_q   <= len_d;
            state_q <= HDR;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        HDR: begin
          drop_q <= wr_en_i;
          if (xfer) begin
            rd_ptr_q <= '0;
            if (len_q == '0) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              valid_q  <= 1'b0;
              done_q   <= 1'b1;
              count_q  <= '0;
              wr_ptr_q <= '0;
            end else begin
              state_q <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          drop_q <= wr_en_i;
          if (xfer) begin
            if (last_w) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              valid_q  <= 1'b0;
              done_q   <= 1'b1;
              count_q  <= '0;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign drop_o      = drop_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_w;
  assign out_last_o  = last_w;

endmodule
